// File: rtl/product_accumulator_if.sv
// Valid/ready bundle between the product stage, the accumulator
// and the downstream consumer of dot-product results.
interface product_accumulator_if #(
    parameter int PROD_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
);
    logic                  flush;
    logic                  prod_valid;
    logic [PROD_WIDTH-1:0] prod_in;
    logic                  prod_ready;
    logic                  sum_valid;
    logic [ACC_WIDTH-1:0]  sum_out;
    logic                  sum_ovf;
    logic                  sum_ready;

    modport master (
        output flush, prod_valid, prod_in, sum_ready,
        input  prod_ready, sum_valid, sum_out, sum_ovf
    );

    modport slave (
        input  flush, prod_valid, prod_in, sum_ready,
        output prod_ready, sum_valid, sum_out, sum_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums VEC_LEN unsigned products into one saturating dot-product
// result with a sticky per-vector overflow flag.
module product_accumulator #(
    parameter int PROD_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int VEC_LEN    = 64
) (
    input logic clk,
    input logic rst,
    product_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);
    localparam bit SINGLE = (VEC_LEN == 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf;

    logic                 take;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum_wide;

    assign bus.prod_ready = (state != HOLD);
    assign bus.sum_valid  = (state == HOLD);
    assign bus.sum_out    = acc;
    assign bus.sum_ovf    = ovf;

    assign take     = bus.prod_valid && bus.prod_ready;
    assign prod_ext = ACC_WIDTH'(bus.prod_in);
    // One extra bit catches the carry that triggers saturation
    assign sum_wide = {1'b0, acc} + {1'b0, prod_ext};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.flush) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (take) begin
                        acc   <= prod_ext;
                        cnt   <= CNT_W'(1);
                        ovf   <= 1'b0;
                        state <= SINGLE ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.flush) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        state <= IDLE;
                    end else if (take) begin
                        if (sum_wide[ACC_WIDTH]) begin
                            acc <= '1;
                            ovf <= 1'b1;
                        end else begin
                            acc <= sum_wide[ACC_WIDTH-1:0];
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.sum_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Table-driven and scoreboard checks of product_accumulator for
// VEC_LEN=4 at 32/17-bit accumulators and for VEC_LEN=1.
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        fl  = 1'b0;
    logic        pv  = 1'b0;
    logic [15:0] pin = '0;
    logic        sr  = 1'b1;
    logic        cv  = 1'b0;
    logic [15:0] cin = '0;
    logic        csr = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    product_accumulator_if #(.PROD_WIDTH(16), .ACC_WIDTH(32)) ia ();
    product_accumulator_if #(.PROD_WIDTH(16), .ACC_WIDTH(17)) ib ();
    product_accumulator_if #(.PROD_WIDTH(16), .ACC_WIDTH(32)) ic ();

    assign ia.flush      = fl;
    assign ia.prod_valid = pv;
    assign ia.prod_in    = pin;
    assign ia.sum_ready  = sr;
    assign ib.flush      = fl;
    assign ib.prod_valid = pv;
    assign ib.prod_in    = pin;
    assign ib.sum_ready  = sr;
    assign ic.flush      = 1'b0;
    assign ic.prod_valid = cv;
    assign ic.prod_in    = cin;
    assign ic.sum_ready  = csr;

    product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(32), .VEC_LEN(4))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(17), .VEC_LEN(4))
        dut_b (.clk(clk), .rst(rst), .bus(ib));
    product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(32), .VEC_LEN(1))
        dut_c (.clk(clk), .rst(rst), .bus(ic));

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [15:0] qc[$];

    typedef struct {
        logic [15:0] p[4];
        int          gap;
        logic [31:0] ea;
        logic        oa;
        logic [31:0] eb;
        logic        ob;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ab(input logic [31:0] a, input logic oa,
                           input logic [31:0] b, input logic ob);
        exp_t e;
        e.sum = a;
        e.ovf = oa;
        qa.push_back(e);
        e.sum = b;
        e.ovf = ob;
        qb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ia.sum_valid && ia.sum_ready) begin
            if (qa.size() == 0) begin
                chk("a_extra_result", 64'(qa.size()), 1);
            end else begin
                e = qa.pop_front();
                chk("a_sum", 64'(ia.sum_out), 64'(e.sum));
                chk("a_ovf", 64'(ia.sum_ovf), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ib.sum_valid && ib.sum_ready) begin
            if (qb.size() == 0) begin
                chk("b_extra_result", 64'(qb.size()), 1);
            end else begin
                e = qb.pop_front();
                chk("b_sum", 64'(ib.sum_out), 64'(e.sum));
                chk("b_ovf", 64'(ib.sum_ovf), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] v;
        if (!rst && ic.sum_valid && ic.sum_ready) begin
            if (qc.size() == 0) begin
                chk("c_extra_result", 64'(qc.size()), 1);
            end else begin
                v = qc.pop_front();
                chk("c_sum", 64'(ic.sum_out), 64'(v));
                chk("c_ovf", 64'(ic.sum_ovf), 0);
            end
        end
    end

    // Caller is aligned #1 after a rising edge; returns the same way.
    task automatic beat(input logic [15:0] v, input int gap);
        int t = 0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        pv  = 1'b1;
        pin = v;
        @(negedge clk);
        while (!ia.prod_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ia.prod_ready) chk("beat_timeout", 64'(ia.prod_ready), 1);
        @(posedge clk);
        #1;
        pv = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0)
               && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_left"}, 64'(qa.size() + qb.size() + qc.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [15:0] p0,
                           input logic [15:0] p1, input logic [15:0] p2,
                           input logic [15:0] p3, input int gap,
                           input logic [31:0] ea, input logic oa,
                           input logic [31:0] eb, input logic ob);
        tbl[i].p[0] = p0;
        tbl[i].p[1] = p1;
        tbl[i].p[2] = p2;
        tbl[i].p[3] = p3;
        tbl[i].gap  = gap;
        tbl[i].ea   = ea;
        tbl[i].oa   = oa;
        tbl[i].eb   = eb;
        tbl[i].ob   = ob;
    endtask

    initial begin
        int nacc;
        set_vec(0, 16'd1, 16'd2, 16'd3, 16'd4, 0,
                32'd10, 1'b0, 32'd10, 1'b0);
        set_vec(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1,
                32'h3FFFC, 1'b0, 32'h1FFFF, 1'b1);
        set_vec(2, 16'd1, 16'd1, 16'd1, 16'd1, 0,
                32'd4, 1'b0, 32'd4, 1'b0);
        set_vec(3, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 0,
                32'h1FFFF, 1'b0, 32'h1FFFF, 1'b0);
        set_vec(4, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000, 2,
                32'h20000, 1'b0, 32'h1FFFF, 1'b1);
        set_vec(5, 16'd0, 16'd0, 16'd0, 16'd0, 0,
                32'd0, 1'b0, 32'd0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a_valid", 64'(ia.sum_valid), 0);
        chk("rst_a_sum", 64'(ia.sum_out), 0);
        chk("rst_a_ovf", 64'(ia.sum_ovf), 0);
        chk("rst_a_ready", 64'(ia.prod_ready), 1);
        chk("rst_c_valid", 64'(ic.sum_valid), 0);
        chk("rst_c_ready", 64'(ic.prod_ready), 1);
        @(posedge clk);
        #1;

        // Backpressure: input kept valid through HOLD must not be taken
        sr = 1'b0;
        push_ab(32'h3FFFC, 1'b0, 32'h1FFFF, 1'b1);
        for (int i = 0; i < 4; i++) beat(16'hFFFF, 2);
        chk("bp_latency", 64'(ia.sum_valid), 1);
        pv  = 1'b1;
        pin = 16'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(ia.sum_valid), 1);
            chk("bp_hold_sum", 64'(ia.sum_out), 64'h3FFFC);
            chk("bp_hold_ready", 64'(ia.prod_ready), 0);
            chk("bp_hold_b_sum", 64'(ib.sum_out), 64'h1FFFF);
        end
        @(posedge clk);
        #1;
        sr = 1'b1;
        @(posedge clk);
        #1;
        pv = 1'b0;
        chk("bp_after_valid", 64'(ia.sum_valid), 0);
        chk("bp_after_ready", 64'(ia.prod_ready), 1);
        chk("bp_left", 64'(qa.size() + qb.size()), 0);

        for (int v = 0; v < 6; v++) begin
            push_ab(tbl[v].ea, tbl[v].oa, tbl[v].eb, tbl[v].ob);
            for (int k = 0; k < 4; k++) beat(tbl[v].p[k], tbl[v].gap);
            chk("tbl_latency", 64'(ia.sum_valid), 1);
            drain("tbl");
            chk("tbl_idle_ready", 64'(ia.prod_ready), 1);
        end

        // Flush mid-vector discards the partial sum and the beat with it
        push_ab(32'd4, 1'b0, 32'd4, 1'b0);
        beat(16'd5, 0);
        beat(16'd6, 0);
        pv  = 1'b1;
        pin = 16'd7;
        fl  = 1'b1;
        @(posedge clk);
        #1;
        fl = 1'b0;
        pv = 1'b0;
        for (int k = 0; k < 4; k++) beat(16'd1, 0);
        drain("flush");

        push_ab(32'd10, 1'b0, 32'd10, 1'b0);
        sr = 1'b0;
        for (int k = 0; k < 4; k++) beat(16'(k + 1), 0);
        fl = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("flush_hold_valid", 64'(ia.sum_valid), 1);
            chk("flush_hold_sum", 64'(ia.sum_out), 10);
        end
        @(posedge clk);
        #1;
        fl = 1'b0;
        sr = 1'b1;
        drain("flush_hold");

        beat(16'd3, 0);
        beat(16'd3, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(ia.sum_valid), 0);
        chk("mid_rst_sum", 64'(ia.sum_out), 0);
        chk("mid_rst_b_sum", 64'(ib.sum_out), 0);
        chk("mid_rst_ready", 64'(ia.prod_ready), 1);
        @(posedge clk);
        #1;
        push_ab(32'd8, 1'b0, 32'd8, 1'b0);
        for (int k = 0; k < 4; k++) beat(16'd2, 0);
        drain("mid_rst");

        // VEC_LEN=1: a continuous stream is taken every other cycle
        nacc = 0;
        cv   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cin = (i % 3 == 0) ? 16'hFFFF : 16'(i * 37 + 1);
            @(negedge clk);
            if (ic.prod_ready) begin
                qc.push_back(cin);
                nacc++;
            end
            @(posedge clk);
            #1;
        end
        cv = 1'b0;
        drain("single");
        chk("c_accept_count", 64'(nacc), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 8x8 unsigned product stage in the attention datapath.
- Sums a fixed-length stream of VEC_LEN unsigned products into one dot-product result, e.g. one QK^T score element.
- Valid/ready on both sides; one result per vector.
- Saturating accumulation with a per-vector overflow flag.

Parameters:
- PROD_WIDTH, 16, width of each incoming unsigned product.
- ACC_WIDTH, 32, width of accumulator and result; must be >= PROD_WIDTH.
- VEC_LEN, 64, number of products summed per result; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort of the vector in progress.
- prod_valid  input  1  prod_in holds a valid product.
- prod_in  input  PROD_WIDTH  unsigned product from the multiplier stage.
- prod_ready  output  1  block accepts prod_in this cycle.
- sum_valid  output  1  sum_out/sum_ovf hold a completed result.
- sum_out  output  ACC_WIDTH  accumulated, saturated result.
- sum_ovf  output  1  a saturation occurred during this vector.
- sum_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, accumulator=0, beat count=0, ovf=0.
  - sum_valid=0, sum_out=0, sum_ovf=0; prod_ready=1 from the first cycle after reset.
  - rst overrides flush and all handshakes. Reset mid-vector discards the partial sum with no output.
- Beat accept: prod_valid && prod_ready at a clk edge. prod_ready is combinational: 1 in IDLE and ACCUM, 0 in HOLD.
- States:
  - IDLE: on accept, accumulator <= zero-extended prod_in, count <= 1, ovf <= 0. Go to ACCUM, or directly to HOLD if VEC_LEN==1.
  - ACCUM: on accept, accumulator <= sat(accumulator + prod_in), count <= count+1. If this accepted beat is number VEC_LEN, go to HOLD. No accept means hold all state; bubbles are allowed anywhere.
  - HOLD: sum_valid=1; sum_out and sum_ovf are stable until handshake. On sum_valid && sum_ready, go to IDLE; sum_valid=0 from the next cycle. No input is accepted in HOLD, including the handshake cycle.
- Latency: sum_valid asserts the cycle after the last beat is accepted.
- Throughput: VEC_LEN+1 cycles per vector minimum: VEC_LEN accept cycles plus one HOLD/handshake cycle.
- Arithmetic:
  - Unsigned, computed at ACC_WIDTH+1 bits.
  - If the true sum exceeds 2^ACC_WIDTH-1, the accumulator clamps to all-ones and ovf becomes 1.
  - ovf is sticky until the next vector starts in IDLE. Once saturated, the accumulator stays all-ones.
- sum_out and sum_ovf reflect the accumulator and ovf registers. They are only meaningful while sum_valid=1, and read 0 after reset until the first result.
- flush:
  - In IDLE or ACCUM: return to IDLE and clear accumulator, count and ovf. Any beat presented in the same cycle is discarded, even if prod_ready=1.
  - In HOLD: flush is ignored; the pending result must be consumed.
- Count width: $clog2(VEC_LEN+1). No wrap is possible because the count resets at each vector start.
- sum_ready while sum_valid=0: ignored.

Test Plan:
- Basic sum: VEC_LEN=4, products 1,2,3,4 back-to-back, sum_ready=1 -> sum_valid one cycle after the 4th beat, sum_out=10, sum_ovf=0, then IDLE with prod_ready=1.
- Bubbles and backpressure: VEC_LEN=4, products 0xFFFF x4 with prod_valid gaps, sum_ready=0 for 5 cycles -> sum_out=0x3FFFC held stable, prod_ready=0 throughout HOLD, single result on sum_ready=1.
- Saturation: ACC_WIDTH=17, VEC_LEN=4, products 0xFFFF x4 -> sum_out=0x1FFFF, sum_ovf=1. Next vector of 1,1,1,1 -> sum_out=4, sum_ovf=0.
- Flush: VEC_LEN=4, accept 5,6, then flush with prod_valid=1 and prod_in=7 -> the 7 is discarded. Next 4 beats of 1 -> sum_out=4. Flush asserted in HOLD -> result still delivered.
- Reset mid-vector: accept 2 of 4 beats, assert rst -> sum_valid=0, sum_out=0. Then 4 beats of 2 -> sum_out=8.
- VEC_LEN=1 and back-to-back vectors: each accepted beat yields sum_valid the next cycle with sum_out=prod_in. A continuous prod_valid stream is accepted every other cycle.
